// File: rtl/ifetch_unit_if.sv
// Instruction memory bus between the fetch unit and instruction memory.
// Ports: imemReq/imemAddr (request), imemReady (accept), imemRValid/imemRData/imemErr (response).
interface ifetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic        imemRValid;
  logic [31:0] imemRData;
  logic        imemErr;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemReady,
    input  imemRValid,
    input  imemRData,
    input  imemErr
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemReady,
    output imemRValid,
    output imemRData,
    output imemErr
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns PC, fetches one word per instruction, holds it for decode.
// Ports: clk, rst, nPC/nPCValid (next PC), imem (memory bus), instValid/instReady/inst/PC (decode), fault, fetchCount.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          nPC,
  input  logic                 nPCValid,
  ifetch_unit_if.master        imem,
  output logic                 instValid,
  input  logic                 instReady,
  output logic [31:0]          inst,
  output logic [31:0]          PC,
  output logic                 fault,
  output logic [31:0]          fetchCount
);

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    HOLD,
    NEXT,
    FAULT
  } state_t;

  state_t state;
  state_t state_next;

  logic aligned;
  logic pc_load;
  logic inst_load;
  logic cnt_inc;

  assign aligned = (PC[1:0] == 2'b00);

  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    inst_load  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      FETCH: begin
        if (!aligned) begin
          state_next = FAULT;
        end else if (imem.imemReady) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem.imemRValid) begin
          if (imem.imemErr) begin
            state_next = FAULT;
          end else begin
            inst_load  = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (instReady) begin
          cnt_inc = 1'b1;
          if (nPCValid) begin
            pc_load    = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = NEXT;
          end
        end
      end
      NEXT: begin
        if (nPCValid) begin
          pc_load    = 1'b1;
          state_next = FETCH;
        end
      end
      FAULT: state_next = FAULT;
      default: state_next = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      PC         <= RESET_PC;
      inst       <= 32'h0;
      fetchCount <= 32'h0;
    end else begin
      state <= state_next;
      if (pc_load) begin
        PC <= nPC;
      end
      if (inst_load) begin
        inst <= imem.imemRData;
      end
      if (cnt_inc) begin
        fetchCount <= fetchCount + 32'd1;
      end
    end
  end

  // While rst is held for several cycles the state already reads FETCH;
  // the request is masked so memory never sees a fetch issued under reset.
  assign imem.imemReq  = ~rst & (state == FETCH) & aligned;
  assign imem.imemAddr = PC;
  assign instValid     = (state == HOLD);
  assign fault         = (state == FAULT);

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: directed scenarios plus a randomized program run.
// Scoreboard queues hold expected fetch addresses and decode words.
module tb_ifetch_unit;
  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] nPC;
  logic        nPCValid;
  logic        instValid;
  logic        instReady;
  logic [31:0] inst;
  logic [31:0] PC;
  logic        fault;
  logic [31:0] fetchCount;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .nPC        (nPC),
    .nPCValid   (nPCValid),
    .imem       (bus),
    .instValid  (instValid),
    .instReady  (instReady),
    .inst       (inst),
    .PC         (PC),
    .fault      (fault),
    .fetchCount (fetchCount)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst && bus.imemReq && bus.imemReady) acc <= acc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // From NEXT: issue nPC, zero-wait fetch, one-cycle decode accept.
  task automatic fetch_one(input logic [31:0] a, output int rc);
    nPCValid = 1'b1;
    nPC = a;
    tick;
    nPCValid = 1'b0;
    bus.imemReady = 1'b1;
    #1;
    chk("seq_req", {31'b0, bus.imemReq}, 32'd1);
    chk("seq_addr", bus.imemAddr, a);
    rc = cyc;
    tick;
    bus.imemReady = 1'b0;
    bus.imemRValid = 1'b1;
    bus.imemRData = memword(a);
    tick;
    bus.imemRValid = 1'b0;
    chk("seq_inst", inst, memword(a));
    chk("seq_pc", PC, a);
    instReady = 1'b1;
    tick;
    instReady = 1'b0;
  endtask

  // ---------------- random-phase model and scoreboard ----------------
  bit          auto = 1'b0;
  logic [31:0] exp_fetch[$];
  logic [31:0] exp_dec[$];
  logic [31:0] cur;
  int          dec_count = 0;

  bit          mbusy, p_acc, p_hs, p_npc_hs, npc_pend;
  int          vwait, nwait;
  logic [31:0] maddr, p_addr;

  task automatic issue_npc;
    logic [31:0] t;
    logic [31:0] nx;
    t = $urandom;
    if ($urandom_range(0, 4) == 0) nx = {16'h0, t[15:2], 2'b00};
    else nx = cur + 32'd4;
    cur = nx;
    exp_fetch.push_back(nx);
    exp_dec.push_back(nx);
    nPCValid = 1'b1;
    nPC = nx;
  endtask

  always @(posedge clk) begin
    #2;
    if (auto) begin
      if (p_acc) begin
        mbusy = 1'b1;
        maddr = p_addr;
        vwait = $urandom_range(0, 3);
      end
      if (p_hs && !p_npc_hs) begin
        npc_pend = 1'b1;
        nwait = $urandom_range(0, 2);
      end
      bus.imemReady = 1'b0;
      bus.imemRValid = 1'b0;
      bus.imemErr = 1'b0;
      nPCValid = 1'b0;
      instReady = 1'b0;
      if (!mbusy && bus.imemReq)
        bus.imemReady = ($urandom_range(0, 2) != 0);
      if (mbusy) begin
        if (vwait == 0) begin
          bus.imemRValid = 1'b1;
          bus.imemRData = memword(maddr);
          mbusy = 1'b0;
        end else begin
          vwait--;
        end
      end
      if (instValid) begin
        instReady = ($urandom_range(0, 3) != 0);
        if (instReady && $urandom_range(0, 3) == 0) issue_npc();
      end else if (npc_pend) begin
        if (nwait == 0) begin
          issue_npc();
          npc_pend = 1'b0;
        end else begin
          nwait--;
        end
      end else if ((bus.imemReq || mbusy) && $urandom_range(0, 5) == 0) begin
        nPCValid = 1'b1;
        nPC = $urandom & 32'hFFFF_FFFC;
      end
      p_acc = bus.imemReq && bus.imemReady;
      p_addr = bus.imemAddr;
      p_hs = instValid && instReady;
      p_npc_hs = p_hs && nPCValid;
    end
  end

  always @(negedge clk) begin
    if (auto) begin
      logic [31:0] a;
      chk("rnd_fault", {31'b0, fault}, 32'd0);
      if (bus.imemReq && bus.imemReady) begin
        if (exp_fetch.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_fetch_extra: got %h expected none", bus.imemAddr);
        end else begin
          a = exp_fetch.pop_front();
          chk("rnd_fetch_addr", bus.imemAddr, a);
        end
      end
      if (instValid && instReady) begin
        if (exp_dec.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_dec_extra: got %h expected none", PC);
        end else begin
          a = exp_dec.pop_front();
          chk("rnd_dec_pc", PC, a);
          chk("rnd_dec_inst", inst, memword(a));
          chk("rnd_dec_cnt", fetchCount, dec_count);
        end
        dec_count++;
      end
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int rc, rp, a0;
    rst = 1'b1;
    nPC = 32'h0;
    nPCValid = 1'b0;
    instReady = 1'b0;
    bus.imemReady = 1'b0;
    bus.imemRValid = 1'b0;
    bus.imemRData = 32'h0;
    bus.imemErr = 1'b0;

    // reset and first fetch
    tick;
    chk("rst_req", {31'b0, bus.imemReq}, 32'd0);
    tick;
    chk("rst_pc", PC, RPC);
    chk("rst_inst", inst, 32'h0);
    chk("rst_cnt", fetchCount, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_ivalid", {31'b0, instValid}, 32'd0);
    rst = 1'b0;
    bus.imemReady = 1'b1;
    #1;
    chk("first_req", {31'b0, bus.imemReq}, 32'd1);
    chk("first_addr", bus.imemAddr, RPC);
    rp = cyc;
    tick;
    bus.imemReady = 1'b0;
    bus.imemRValid = 1'b1;
    bus.imemRData = 32'h2408_0005;
    chk("wait_noreq", {31'b0, bus.imemReq}, 32'd0);
    tick;
    bus.imemRValid = 1'b0;
    chk("first_ivalid", {31'b0, instValid}, 32'd1);
    chk("first_inst", inst, 32'h2408_0005);
    chk("first_pc", PC, RPC);
    chk("first_lat", cyc - rp, 32'd2);
    instReady = 1'b1;
    tick;
    instReady = 1'b0;
    chk("first_drop", {31'b0, instValid}, 32'd0);
    chk("first_cnt", fetchCount, 32'd1);

    // sequential stream, one instruction every 4 cycles
    for (int i = 1; i < 4; i++) begin
      fetch_one(RPC + 32'(4 * i), rc);
      chk("seq_spacing", rc - rp, 32'd4);
      rp = rc;
    end
    chk("seq_cnt", fetchCount, 32'd4);

    // backpressure and late nPC
    nPCValid = 1'b1;
    nPC = 32'h3010;
    tick;
    nPCValid = 1'b0;
    bus.imemReady = 1'b1;
    tick;
    bus.imemReady = 1'b0;
    bus.imemRValid = 1'b1;
    bus.imemRData = memword(32'h3010);
    tick;
    bus.imemRValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_ivalid", {31'b0, instValid}, 32'd1);
      chk("stall_inst", inst, memword(32'h3010));
      chk("stall_pc", PC, 32'h3010);
      tick;
    end
    instReady = 1'b1;
    tick;
    instReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("next_ivalid", {31'b0, instValid}, 32'd0);
      chk("next_req", {31'b0, bus.imemReq}, 32'd0);
      if (i < 2) tick;
    end
    nPCValid = 1'b1;
    nPC = 32'h3040;
    tick;
    nPCValid = 1'b0;
    chk("late_req", {31'b0, bus.imemReq}, 32'd1);
    chk("late_addr", bus.imemAddr, 32'h3040);
    chk("late_cnt", fetchCount, 32'd5);

    // memory wait states with stray nPC pulses
    a0 = acc;
    for (int i = 0; i < 3; i++) begin
      nPCValid = (i == 1);
      nPC = 32'h5000;
      chk("ws_fetch_pc", PC, 32'h3040);
      chk("ws_fetch_req", {31'b0, bus.imemReq}, 32'd1);
      tick;
    end
    nPCValid = 1'b0;
    bus.imemReady = 1'b1;
    tick;
    bus.imemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nPCValid = (i == 1);
      nPC = 32'h6000;
      chk("ws_wait_req", {31'b0, bus.imemReq}, 32'd0);
      chk("ws_wait_pc", PC, 32'h3040);
      tick;
    end
    nPCValid = 1'b0;
    bus.imemRValid = 1'b1;
    bus.imemRData = memword(32'h3040);
    tick;
    bus.imemRValid = 1'b0;
    chk("ws_inst", inst, memword(32'h3040));
    chk("ws_pc", PC, 32'h3040);
    instReady = 1'b1;
    tick;
    instReady = 1'b0;
    chk("ws_cnt", fetchCount, 32'd6);
    chk("ws_accepts", acc - a0, 32'd1);
    tick;
    chk("ws_once", {31'b0, instValid}, 32'd0);

    // misaligned nPC fault
    nPCValid = 1'b1;
    nPC = 32'h3002;
    bus.imemReady = 1'b1;
    tick;
    nPCValid = 1'b0;
    chk("mis_noreq", {31'b0, bus.imemReq}, 32'd0);
    chk("mis_pc", PC, 32'h3002);
    tick;
    chk("mis_fault", {31'b0, fault}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("mis_hold", {31'b0, fault}, 32'd1);
      chk("mis_hold_req", {31'b0, bus.imemReq}, 32'd0);
    end
    bus.imemReady = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("clr_fault", {31'b0, fault}, 32'd0);
    chk("clr_pc", PC, RPC);
    chk("clr_cnt", fetchCount, 32'd0);

    // bus error fault
    bus.imemReady = 1'b1;
    #1;
    chk("err_req", {31'b0, bus.imemReq}, 32'd1);
    tick;
    bus.imemReady = 1'b0;
    bus.imemRValid = 1'b1;
    bus.imemErr = 1'b1;
    bus.imemRData = 32'hDEAD_BEEF;
    tick;
    bus.imemRValid = 1'b0;
    bus.imemErr = 1'b0;
    chk("err_fault", {31'b0, fault}, 32'd1);
    chk("err_inst", inst, 32'h0);
    instReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("err_noivalid", {31'b0, instValid}, 32'd0);
      tick;
    end
    instReady = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("err_clr", {31'b0, fault}, 32'd0);
    chk("err_restart", bus.imemAddr, RPC);
    chk("err_restart_req", {31'b0, bus.imemReq}, 32'd1);

    // reset with a read outstanding
    bus.imemReady = 1'b1;
    tick;
    bus.imemReady = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.imemRValid = 1'b1;
    bus.imemRData = 32'hBAD0_BAD0;
    #1;
    chk("mr_req", {31'b0, bus.imemReq}, 32'd1);
    chk("mr_addr", bus.imemAddr, RPC);
    tick;
    bus.imemRValid = 1'b0;
    chk("mr_stray", {31'b0, instValid}, 32'd0);
    chk("mr_req2", {31'b0, bus.imemReq}, 32'd1);
    chk("mr_cnt", fetchCount, 32'd0);
    bus.imemReady = 1'b1;
    tick;
    bus.imemReady = 1'b0;
    bus.imemRValid = 1'b1;
    bus.imemRData = memword(RPC);
    tick;
    bus.imemRValid = 1'b0;
    chk("mr_inst", inst, memword(RPC));
    instReady = 1'b1;
    tick;
    instReady = 1'b0;
    chk("mr_cnt2", fetchCount, 32'd1);

    // randomized program run
    rst = 1'b1;
    tick;
    rst = 1'b0;
    cur = RPC;
    exp_fetch.push_back(RPC);
    exp_dec.push_back(RPC);
    mbusy = 1'b0;
    p_acc = 1'b0;
    p_hs = 1'b0;
    p_npc_hs = 1'b0;
    npc_pend = 1'b0;
    auto = 1'b1;
    for (int i = 0; i < 6000 && dec_count < 40; i++) @(negedge clk);
    if (dec_count < 40) begin
      checks++;
      errors++;
      $display("FAIL rnd_timeout: got %0d expected 40", dec_count);
    end
    auto = 1'b0;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
